// File: rtl/demux_1to2_stream_pkg.sv
// Shared constants for the stream blocks: channel indices and default widths.
package demux_1to2_stream_pkg;
  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;
  localparam int   DEFAULT_WIDTH     = 8;
  localparam int   DEFAULT_CNT_WIDTH = 16;
endpackage

// File: rtl/demux_1to2_stream_slot.sv
// One registered output channel: data register, valid flag, free indication
// and a wrapping count of delivered beats.
module stream_out_slot
  import demux_1to2_stream_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic [WIDTH-1:0]     i_data,
  input  logic                 i_ready,
  output logic [WIDTH-1:0]     o_data,
  output logic                 o_valid,
  output logic                 o_free,
  output logic [CNT_WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0]     r_data;
  logic                 r_valid;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_drain;

  assign w_drain = r_valid && i_ready;
  // Free when empty or emptying this edge, so drain and reload can overlap.
  assign o_free  = !r_valid || i_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (i_load) begin
        r_data  <= i_data;
        r_valid <= 1'b1;
      end else if (w_drain) begin
        r_valid <= 1'b0;
      end
      if (w_drain) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/demux_1to2_stream.sv
// Registered 1-to-2 stream demultiplexer: each input beat is steered by sel
// into one of two single-entry output slots.
module demux_1to2_stream
  import demux_1to2_stream_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     d,
  input  logic                 sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     y0,
  output logic                 y0_valid,
  input  logic                 y0_ready,
  output logic [WIDTH-1:0]     y1,
  output logic                 y1_valid,
  input  logic                 y1_ready,
  output logic [CNT_WIDTH-1:0] cnt0,
  output logic [CNT_WIDTH-1:0] cnt1
);

  logic [1:0]           w_free;
  logic [1:0]           w_load;
  logic [1:0]           w_ready;
  logic [1:0]           w_valid;
  logic [WIDTH-1:0]     w_data [2];
  logic [CNT_WIDTH-1:0] w_cnt  [2];
  logic                 w_accept;

  // Head-of-line: only the targeted slot matters, never in_valid.
  assign in_ready = sel ? w_free[CH1] : w_free[CH0];
  assign w_accept = in_valid && in_ready;

  assign w_ready[CH0] = y0_ready;
  assign w_ready[CH1] = y1_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      assign w_load[gi] = w_accept && (sel == 1'(gi));

      stream_out_slot #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
      ) u_slot (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load[gi]),
        .i_data  (d),
        .i_ready (w_ready[gi]),
        .o_data  (w_data[gi]),
        .o_valid (w_valid[gi]),
        .o_free  (w_free[gi]),
        .o_cnt   (w_cnt[gi])
      );
    end
  endgenerate

  assign y0       = w_data[CH0];
  assign y0_valid = w_valid[CH0];
  assign cnt0     = w_cnt[CH0];
  assign y1       = w_data[CH1];
  assign y1_valid = w_valid[CH1];
  assign cnt1     = w_cnt[CH1];

endmodule

// File: tb/tb_demux_1to2_stream.sv
// Directed bench for demux_1to2_stream with WIDTH=8, CNT_WIDTH=4.
module tb_demux_1to2_stream;
  import demux_1to2_stream_pkg::*;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic [W-1:0]  d;
  logic          sel;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  y0;
  logic          y0_valid;
  logic          y0_ready;
  logic [W-1:0]  y1;
  logic          y1_valid;
  logic          y1_ready;
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;

  int compared;
  int mismatched;

  demux_1to2_stream #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .d        (d),
    .sel      (sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y0       (y0),
    .y0_valid (y0_valid),
    .y0_ready (y0_ready),
    .y1       (y1),
    .y1_valid (y1_valid),
    .y1_ready (y1_ready),
    .cnt0     (cnt0),
    .cnt1     (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs are changed and outputs read 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; d = '0; sel = 1'b0; in_valid = 1'b0; y0_ready = 1'b0; y1_ready = 1'b0;
    #2;
    compared++; if (y0_valid !== 1'b0 || y1_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valids: got %b%b want 00", y1_valid, y0_valid); end
    compared++; if (cnt0 !== 4'd0 || cnt1 !== 4'd0) begin mismatched++; $display("FAIL reset_cnts: got %0d/%0d want 0/0", cnt0, cnt1); end
    tick();
    rst = 1'b0;
    d = 8'hAA; sel = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    compared++; if (y0 !== 8'hAA || y0_valid !== 1'b1) begin mismatched++; $display("FAIL reset_preload: got y0=%h v=%b want AA 1", y0, y0_valid); end
    #3 rst = 1'b1;
    #1;
    $display("reset pulse mid-cycle: y0=%h v=%b cnt0=%0d in_ready=%b", y0, y0_valid, cnt0, in_ready);
    compared++; if (y0_valid !== 1'b0) begin mismatched++; $display("FAIL reset_async_valid: got %b want 0", y0_valid); end
    compared++; if (y0 !== 8'h00) begin mismatched++; $display("FAIL reset_async_data: got %h want 00", y0); end
    compared++; if (cnt0 !== 4'd0) begin mismatched++; $display("FAIL reset_async_cnt: got %0d want 0", cnt0); end
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    #1 rst = 1'b0;
    tick();
    compared++; if (y0_valid !== 1'b0) begin mismatched++; $display("FAIL reset_no_ghost: got %b want 0", y0_valid); end
  endtask

  task automatic test_routing();
    y0_ready = 1'b1; y1_ready = 1'b1;
    d = 8'h11; sel = 1'b0; in_valid = 1'b1;
    tick();
    $display("route d=11 sel=0: y0=%h v=%b", y0, y0_valid);
    compared++; if (y0 !== 8'h11 || y0_valid !== 1'b1) begin mismatched++; $display("FAIL route_y0: got %h v=%b want 11 1", y0, y0_valid); end
    d = 8'h22; sel = 1'b1;
    tick();
    in_valid = 1'b0;
    $display("route d=22 sel=1: y1=%h v=%b", y1, y1_valid);
    compared++; if (y1 !== 8'h22 || y1_valid !== 1'b1) begin mismatched++; $display("FAIL route_y1: got %h v=%b want 22 1", y1, y1_valid); end
    compared++; if (y0_valid !== 1'b0) begin mismatched++; $display("FAIL route_y0_drained: got %b want 0", y0_valid); end
    tick();
    compared++; if (cnt0 !== 4'd1 || cnt1 !== 4'd1) begin mismatched++; $display("FAIL route_cnts: got %0d/%0d want 1/1", cnt0, cnt1); end
  endtask

  task automatic test_backpressure();
    y0_ready = 1'b0;
    d = 8'h33; sel = 1'b0; in_valid = 1'b1;
    tick();
    d = 8'h44;
    #1;
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_in_ready_low: got %b want 0", in_ready); end
    tick();
    $display("backpressure stall: y0=%h v=%b in_ready=%b", y0, y0_valid, in_ready);
    compared++; if (y0 !== 8'h33 || y0_valid !== 1'b1) begin mismatched++; $display("FAIL bp_hold: got %h v=%b want 33 1", y0, y0_valid); end
    y0_ready = 1'b1;
    #1;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL bp_in_ready_high: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    compared++; if (y0 !== 8'h44 || y0_valid !== 1'b1) begin mismatched++; $display("FAIL bp_reload: got %h v=%b want 44 1", y0, y0_valid); end
    tick();
    compared++; if (cnt0 !== 4'd3 || y0_valid !== 1'b0) begin mismatched++; $display("FAIL bp_cnt: got cnt0=%0d v=%b want 3 0", cnt0, y0_valid); end
  endtask

  task automatic test_hol_blocking();
    y0_ready = 1'b0; y1_ready = 1'b0;
    d = 8'h55; sel = 1'b0; in_valid = 1'b1;
    tick();
    d = 8'h66;
    #1;
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL hol_in_ready: got %b want 0", in_ready); end
    tick();
    tick();
    $display("hol blocked: y0=%h y1_valid=%b in_ready=%b", y0, y1_valid, in_ready);
    compared++; if (y1_valid !== 1'b0) begin mismatched++; $display("FAIL hol_y1_valid: got %b want 0", y1_valid); end
    compared++; if (y0 !== 8'h55) begin mismatched++; $display("FAIL hol_y0_hold: got %h want 55", y0); end
    in_valid = 1'b0; y0_ready = 1'b1;
    tick();
    compared++; if (cnt0 !== 4'd4) begin mismatched++; $display("FAIL hol_cnt0: got %0d want 4", cnt0); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]  exp_d;
    logic [CW-1:0] exp_c;
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    y0_ready = 1'b0; y1_ready = 1'b1;
    sel = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      exp_d = W'(i);
      exp_c = CW'(i);
      d = exp_d;
      #1;
      compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); end
      tick();
      $display("b2b beat %0d: y1=%h v=%b cnt1=%0d", i, y1, y1_valid, cnt1);
      compared++; if (y1 !== exp_d || y1_valid !== 1'b1) begin mismatched++; $display("FAIL b2b_data[%0d]: got %h v=%b want %h 1", i, y1, y1_valid, exp_d); end
      compared++; if (cnt1 !== exp_c) begin mismatched++; $display("FAIL b2b_cnt[%0d]: got %0d want %0d", i, cnt1, exp_c); end
    end
    in_valid = 1'b0;
    tick();
    compared++; if (cnt1 !== 4'd4 || y1_valid !== 1'b0) begin mismatched++; $display("FAIL b2b_final: got cnt1=%0d v=%b want 4 0", cnt1, y1_valid); end
  endtask

  task automatic test_dual_drain();
    y0_ready = 1'b0; y1_ready = 1'b0;
    d = 8'h77; sel = 1'b0; in_valid = 1'b1;
    tick();
    d = 8'h88; sel = 1'b1;
    tick();
    in_valid = 1'b0;
    compared++; if (y0 !== 8'h77 || y1 !== 8'h88 || y0_valid !== 1'b1 || y1_valid !== 1'b1) begin
      mismatched++; $display("FAIL dual_full: got y0=%h/%b y1=%h/%b want 77/1 88/1", y0, y0_valid, y1, y1_valid);
    end
    y0_ready = 1'b1; y1_ready = 1'b1;
    tick();
    $display("dual drain: v=%b%b cnt0=%0d cnt1=%0d", y1_valid, y0_valid, cnt0, cnt1);
    compared++; if (y0_valid !== 1'b0 || y1_valid !== 1'b0) begin mismatched++; $display("FAIL dual_valids: got %b%b want 00", y1_valid, y0_valid); end
    compared++; if (cnt0 !== 4'd1 || cnt1 !== 4'd5) begin mismatched++; $display("FAIL dual_cnts: got %0d/%0d want 1/5", cnt0, cnt1); end
    compared++; if (y0 !== 8'h77 || y1 !== 8'h88) begin mismatched++; $display("FAIL dual_data_hold: got %h/%h want 77/88", y0, y1); end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_routing();
    test_backpressure();
    test_hol_blocking();
    test_back_to_back();
    test_dual_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
